capture_controller: RTL and testbench
=====================================

CAPTURE_CONTROLLER -- requirements
Module: capture_controller

Interface
REQ-001 SHALL have parameter MDW, default 32, sample/memory data width.
REQ-002 SHALL have parameter MKW, default 4, byte-keep width (MDW/8).
REQ-003 SHALL have parameter CW, default 16, width of delay/read counters.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port arm, input, 1, one-cycle pulse that starts a capture.
REQ-007 SHALL have port abort, input, 1, one-cycle pulse that returns the block to IDLE.
REQ-008 SHALL have port cfg_fwd, input, CW, number of post-trigger samples to store.
REQ-009 SHALL have port cfg_rdc, input, CW, number of samples to read back.
REQ-010 SHALL have port trigger, input, 1, trigger-hit strobe, qualified by smp_tvalid.
REQ-011 SHALL have ports smp_tvalid/smp_tkeep/smp_tdata, input, 1/MKW/MDW, incoming sample stream with no back-pressure.
REQ-012 SHALL have ports mwr_tvalid/mwr_tlast/mwr_tkeep/mwr_tdata, output, 1/1/MKW/MDW, SRAM write stream.
REQ-013 SHALL have port mrd_tready, output, 1, one-cycle SRAM read request that steps the address backwards.
REQ-014 SHALL have ports mrd_tvalid/mrd_tdata, input, 1/MDW, SRAM read data, valid one cycle after the request.
REQ-015 SHALL have ports tx_tvalid/tx_tdata/tx_tready, out/out/in, 1/MDW/1, readback stream toward the transmitter.
REQ-016 SHALL have port init, output, 1, one-cycle pulse on arm that resets the SRAM address.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-018 SHALL implement the states IDLE, SAMPLE, DELAY, READ, WAIT and SEND.
REQ-019 IDLE: on arm, SHALL pulse init, latch cfg_fwd and cfg_rdc, and go to SAMPLE.
REQ-020 SAMPLE: each smp_tvalid SHALL produce mwr_tvalid the next cycle, with the registered smp_tdata/smp_tkeep and mwr_tlast=0.
REQ-021 SAMPLE: smp_tvalid&trigger SHALL write that sample and go to DELAY with fwd counter = latched cfg_fwd.
REQ-022 DELAY: each valid sample SHALL be written and SHALL decrement the counter.
REQ-023 DELAY: the sample written when the counter reaches 0 SHALL carry mwr_tlast=1, then the block SHALL go to READ.
REQ-024 DELAY: with cfg_fwd=0, the trigger sample itself SHALL carry mwr_tlast=1.
REQ-025 READ: the block SHALL assert mrd_tready for exactly one cycle, then go to WAIT.
REQ-026 WAIT: on mrd_tvalid, SHALL capture mrd_tdata into tx_tdata, assert tx_tvalid, and go to SEND.
REQ-027 SEND: tx_tvalid/tx_tdata SHALL hold stable until tx_tready.
REQ-028 SEND: on the tx_tvalid&tx_tready handshake, the read counter SHALL decrement; at 0 the block SHALL go to IDLE, otherwise to READ.
REQ-029 Total readback SHALL be exactly cfg_rdc+1 words, most recent first.
REQ-030 mwr_tvalid SHALL never be asserted outside SAMPLE/DELAY (one-cycle pipeline tail excepted).
REQ-031 mrd_tready SHALL never coincide with mwr_tvalid.
REQ-032 abort SHALL win over every other event and SHALL force IDLE next cycle; tx_tvalid, mwr_tvalid and mrd_tready SHALL drop.
REQ-033 arm outside IDLE SHALL be ignored.
REQ-034 Counters SHALL be CW bits and SHALL not wrap (decrement only while nonzero).
REQ-035 Throughput: 1 word per 3 cycles minimum in readback when tx_tready is held high.

Reset
REQ-036 rst SHALL force IDLE and clear both counters.
REQ-037 rst SHALL drive busy, init, mwr_tvalid, mwr_tlast, mrd_tready and tx_tvalid to 0, and mwr_tkeep/tdata and tx_tdata to 0.
REQ-038 rst mid-capture or mid-readback SHALL behave as REQ-036/037 with no further memory access.

Configuration
REQ-039 Macro CAPTURE_COUNT_EN, when defined, SHALL add output cap_count[CW-1:0]: samples written since the last arm, saturating at all-ones, cleared by arm/rst.
REQ-040 Without CAPTURE_COUNT_EN, the port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-041 The state encoding and the default widths (MDW, MKW, CW) SHALL live in the shared package capture_pkg.
REQ-042 The block SHALL contain one sub-module, down_counter (load/decrement/zero flag), instantiated for both the fwd and read counters.

Verification
REQ-043 cfg_fwd=3, trigger on the 5th valid sample -> 9 writes in total, mwr_tlast only on the 9th, then READ.
REQ-044 cfg_fwd=0 -> the trigger sample is written with mwr_tlast=1.
REQ-045 cfg_rdc=2, tx_tready tied high -> exactly 3 mrd_tready pulses and 3 tx handshakes, then busy=0.
REQ-046 tx_tready held low for 10 cycles in SEND -> tx_tdata stable for all 10 cycles, and no new mrd_tready.
REQ-047 abort during DELAY -> IDLE next cycle with no further writes; rst during SEND -> tx_tvalid=0 next cycle.
REQ-048 CAPTURE_COUNT_EN defined, 7 samples written -> cap_count=7, and cap_count=0 after the next arm.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared definitions for the capture controller: default widths, FSM state encoding
// and a small state-decode helper.
package capture_pkg;

    localparam int unsigned CAP_MDW = 32;
    localparam int unsigned CAP_MKW = CAP_MDW / 8;
    localparam int unsigned CAP_CW  = 16;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StSample = 3'd1;
    localparam state_t StDelay  = 3'd2;
    localparam state_t StRead   = 3'd3;
    localparam state_t StWait   = 3'd4;
    localparam state_t StSend   = 3'd5;

    // True in the states that store incoming samples.
    function automatic logic is_capturing(input state_t s);
        return (s == StSample) || (s == StDelay);
    endfunction

endpackage

// File: rtl/capture_controller_if.sv
// Stream bundle of the capture controller: sample input, SRAM write/read and the
// readback stream. master = the controller, slave = its environment.
interface capture_controller_if #(
    parameter int unsigned MDW = capture_pkg::CAP_MDW,
    parameter int unsigned MKW = capture_pkg::CAP_MKW
);

    logic           smp_tvalid;
    logic [MKW-1:0] smp_tkeep;
    logic [MDW-1:0] smp_tdata;
    logic           trigger;

    logic           mwr_tvalid;
    logic           mwr_tlast;
    logic [MKW-1:0] mwr_tkeep;
    logic [MDW-1:0] mwr_tdata;

    logic           mrd_tready;
    logic           mrd_tvalid;
    logic [MDW-1:0] mrd_tdata;

    logic           tx_tvalid;
    logic [MDW-1:0] tx_tdata;
    logic           tx_tready;

    modport master (
        input  smp_tvalid, smp_tkeep, smp_tdata, trigger,
        input  mrd_tvalid, mrd_tdata, tx_tready,
        output mwr_tvalid, mwr_tlast, mwr_tkeep, mwr_tdata,
        output mrd_tready, tx_tvalid, tx_tdata
    );

    modport slave (
        output smp_tvalid, smp_tkeep, smp_tdata, trigger,
        output mrd_tvalid, mrd_tdata, tx_tready,
        input  mwr_tvalid, mwr_tlast, mwr_tkeep, mwr_tdata,
        input  mrd_tready, tx_tvalid, tx_tdata
    );

endinterface

// File: rtl/down_counter.sv
// Loadable down counter with a zero flag; it holds at zero instead of wrapping.
module down_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;

    // Load wins over decrement; decrement only while nonzero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/capture_controller.sv
// Capture controller: stores a sample stream into SRAM around a trigger, then reads
// the most recent words back (newest first) toward a transmitter.
// Optional feature: define CAPTURE_COUNT_EN to add the cap_count output.
module capture_controller
    import capture_pkg::*;
#(
    parameter int unsigned MDW = CAP_MDW,
    parameter int unsigned MKW = CAP_MKW,
    parameter int unsigned CW  = CAP_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          abort,
    input  logic [CW-1:0] cfg_fwd,
    input  logic [CW-1:0] cfg_rdc,
    output logic          init,
    output logic          busy,
`ifdef CAPTURE_COUNT_EN
    output logic [CW-1:0] cap_count,
`endif
    capture_controller_if.master bus
);

    state_t         state_q, state_d;
    logic           init_q;
    logic           mwr_tvalid_q, mwr_tlast_q;
    logic [MKW-1:0] mwr_tkeep_q;
    logic [MDW-1:0] mwr_tdata_q;
    logic           tx_tvalid_q;
    logic [MDW-1:0] tx_tdata_q;

    logic arm_ok, smp_write, last_write, fwd_dec, mrd_req, tx_hs;
    logic fwd_zero, rd_zero;

    // Decode per-cycle events; abort suppresses every one of them.
    always_comb begin
        arm_ok     = (state_q == StIdle) && arm && !abort;
        smp_write  = is_capturing(state_q) && bus.smp_tvalid && !abort;
        // In SAMPLE only the trigger sample can be last (cfg_fwd == 0); in DELAY the
        // sample taken while the counter already sits at zero closes the capture.
        last_write = smp_write && fwd_zero && ((state_q == StDelay) || bus.trigger);
        fwd_dec    = (state_q == StDelay) && smp_write;
        // Hold the read request while the final write is still on the bus.
        mrd_req    = (state_q == StRead) && !mwr_tvalid_q && !abort && !rst;
        tx_hs      = (state_q == StSend) && tx_tvalid_q && bus.tx_tready && !abort;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (arm) state_d = StSample;
                StSample: if (smp_write && bus.trigger) state_d = fwd_zero ? StRead : StDelay;
                StDelay:  if (last_write) state_d = StRead;
                StRead:   if (mrd_req) state_d = StWait;
                StWait:   if (bus.mrd_tvalid) state_d = StSend;
                StSend:   if (tx_hs) state_d = rd_zero ? StIdle : StRead;
                default:  state_d = StIdle;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            init_q       <= 1'b0;
            mwr_tvalid_q <= 1'b0;
            mwr_tlast_q  <= 1'b0;
            mwr_tkeep_q  <= '0;
            mwr_tdata_q  <= '0;
            tx_tvalid_q  <= 1'b0;
            tx_tdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            init_q       <= arm_ok;
            mwr_tvalid_q <= smp_write;
            mwr_tlast_q  <= last_write;
            if (smp_write) begin
                mwr_tkeep_q <= bus.smp_tkeep;
                mwr_tdata_q <= bus.smp_tdata;
            end
            if (abort) begin
                tx_tvalid_q <= 1'b0;
            end else if ((state_q == StWait) && bus.mrd_tvalid) begin
                tx_tvalid_q <= 1'b1;
                tx_tdata_q  <= bus.mrd_tdata;
            end else if (tx_hs) begin
                tx_tvalid_q <= 1'b0;
            end
        end
    end

    // Both counters take their configuration at arm, which doubles as the latch.
    down_counter #(
        .W(CW)
    ) u_fwd_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (arm_ok),
        .load_val (cfg_fwd),
        .dec      (fwd_dec),
        .zero     (fwd_zero)
    );

    down_counter #(
        .W(CW)
    ) u_rd_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (arm_ok),
        .load_val (cfg_rdc),
        .dec      (tx_hs),
        .zero     (rd_zero)
    );

`ifdef CAPTURE_COUNT_EN
    logic [CW-1:0] cap_count_q;

    // Count write beats since the last arm, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst || arm_ok) begin
            cap_count_q <= '0;
        end else if (mwr_tvalid_q && (cap_count_q != '1)) begin
            cap_count_q <= cap_count_q + CW'(1);
        end
    end

    assign cap_count = cap_count_q;
`endif

    assign init           = init_q;
    assign busy           = (state_q != StIdle);
    assign bus.mwr_tvalid = mwr_tvalid_q;
    assign bus.mwr_tlast  = mwr_tlast_q;
    assign bus.mwr_tkeep  = mwr_tkeep_q;
    assign bus.mwr_tdata  = mwr_tdata_q;
    assign bus.mrd_tready = mrd_req;
    assign bus.tx_tvalid  = tx_tvalid_q;
    assign bus.tx_tdata   = tx_tdata_q;

endmodule

// File: tb/tb_capture_controller.sv
// Self-checking bench for capture_controller: scenario table, randomized captures
// against a reference model, and hand-written abort/reset/back-pressure sequences.
module tb_capture_controller;

    localparam int MDW = 32;
    localparam int MKW = 4;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst, arm, abort;
    logic [CW-1:0] cfg_fwd, cfg_rdc;
    logic          init, busy;
`ifdef CAPTURE_COUNT_EN
    logic [CW-1:0] cap_count;
`endif

    capture_controller_if #(.MDW(MDW), .MKW(MKW)) bus ();

    capture_controller #(
        .MDW(MDW),
        .MKW(MKW),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .abort     (abort),
        .cfg_fwd   (cfg_fwd),
        .cfg_rdc   (cfg_rdc),
        .init      (init),
        .busy      (busy),
`ifdef CAPTURE_COUNT_EN
        .cap_count (cap_count),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor plus a behavioural SRAM: writes go up from address 0 after init, each
    // read request steps the address back and returns that word one cycle later.
    logic [MKW+MDW-1:0] wr_q[$];
    bit                 wl_q[$];
    logic [MDW-1:0]     tx_q[$];
    int                 rd_pulses = 0, overlap = 0, mon_cyc = 0, last_hs = -1, max_gap = 0;
    logic [MDW-1:0]     sram [256];
    logic [7:0]         sram_wp = 8'd0, sram_rp = 8'd0;
    logic               sram_pend = 1'b0;
    logic [MDW-1:0]     sram_pend_data = '0;

    always @(negedge clk) begin
        mon_cyc++;
        sram_pend = 1'b0;
        if (init === 1'b1) sram_wp = 8'd0;
        if (bus.mwr_tvalid === 1'b1) begin
            wr_q.push_back({bus.mwr_tkeep, bus.mwr_tdata});
            wl_q.push_back(bus.mwr_tlast === 1'b1);
            sram[sram_wp] = bus.mwr_tdata;
            sram_wp++;
            sram_rp = sram_wp;
        end
        if (bus.mrd_tready === 1'b1) begin
            rd_pulses++;
            if (bus.mwr_tvalid === 1'b1) overlap++;
            sram_rp--;
            sram_pend      = 1'b1;
            sram_pend_data = sram[sram_rp];
        end
        if (bus.tx_tvalid === 1'b1 && bus.tx_tready === 1'b1) begin
            tx_q.push_back(bus.tx_tdata);
            if (last_hs >= 0 && mon_cyc - last_hs > max_gap) max_gap = mon_cyc - last_hs;
            last_hs = mon_cyc;
        end
    end

    always @(posedge clk) begin
        bus.mrd_tvalid <= sram_pend;
        bus.mrd_tdata  <= sram_pend_data;
    end

    task automatic clear_mon();
        wr_q.delete();
        wl_q.delete();
        tx_q.delete();
        rd_pulses = 0;
        last_hs   = -1;
        max_gap   = 0;
    endtask

    // Reference: the trigger sample and everything before it since arm is stored;
    // a nonzero cfg_fwd adds cfg_fwd+1 samples after the trigger.
    function automatic int model_writes(input int fwd, input int trig);
        return trig + ((fwd == 0) ? 0 : fwd + 1);
    endfunction

    // One full arm/capture/readback; the trigger rides on the trig_n-th valid sample.
    task automatic run_capture(input string tag, input int fwd, input int rdc, input int trig_n,
                               input int exp_w, input int exp_r, input bit rnd_ready);
        logic [MKW+MDW-1:0] drv_q[$];
        int nvalid = 0, cyc = 0, derr = 0, terr = 0, lastpos = -1, nlast = 0;
        bit done = 1'b0, v;
        logic [MDW-1:0] d;
        logic [MKW-1:0] k;
        clear_mon();
        cfg_fwd = CW'(fwd);
        cfg_rdc = CW'(rdc);
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk({tag, "_init"}, {63'd0, init}, 64'd1);
        while (!done && cyc < 2000) begin
            v = (nvalid < exp_w + 3) && ($urandom_range(0, 3) != 0);
            d = $urandom;
            k = MKW'($urandom);
            bus.smp_tvalid = v;
            bus.smp_tdata  = d;
            bus.smp_tkeep  = k;
            if (v) begin
                nvalid++;
                bus.trigger = (nvalid == trig_n) || (nvalid > trig_n && $urandom_range(0, 1) == 1);
                if (nvalid <= exp_w) drv_q.push_back({k, d});
            end else begin
                bus.trigger = ($urandom_range(0, 1) == 1);
            end
            bus.tx_tready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            step();
            cyc++;
            if (nvalid >= exp_w + 3 && busy === 1'b0) done = 1'b1;
        end
        bus.smp_tvalid = 1'b0;
        bus.trigger    = 1'b0;
        bus.tx_tready  = 1'b1;
        step();
        chk({tag, "_finished"}, {63'd0, done}, 64'd1);
        chk({tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_w));
        for (int i = 0; i < wr_q.size() && i < drv_q.size(); i++)
            if (wr_q[i] !== drv_q[i]) derr++;
        for (int i = 0; i < wl_q.size(); i++) begin
            if (wl_q[i]) begin
                nlast++;
                if (lastpos < 0) lastpos = i;
            end
        end
        chk({tag, "_wr_data"}, 64'(derr), 64'd0);
        chk({tag, "_tlast_cnt"}, 64'(nlast), 64'd1);
        chk({tag, "_tlast_pos"}, 64'(lastpos), 64'(exp_w - 1));
        chk({tag, "_rd_pulses"}, 64'(rd_pulses), 64'(exp_r));
        chk({tag, "_tx_count"}, 64'(tx_q.size()), 64'(exp_r));
        for (int i = 0; i < tx_q.size(); i++) begin
            if (exp_w - 1 - i < 0 || exp_w - 1 - i >= drv_q.size()) terr++;
            else if (tx_q[i] !== drv_q[exp_w - 1 - i][MDW-1:0]) terr++;
        end
        chk({tag, "_tx_data"}, 64'(terr), 64'd0);
        if (!rnd_ready && exp_r > 1) chk({tag, "_tput"}, 64'(max_gap <= 3), 64'd1);
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    typedef struct {
        int fwd;
        int rdc;
        int trig;
        int exp_w;
        int exp_r;
        bit rnd;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int p, n, serr, cyc, fwd, trig, w, rdc;
        logic [MDW-1:0] d;

        vecs[0] = '{3, 2, 5, 9, 3, 1'b0};
        vecs[1] = '{0, 0, 1, 1, 1, 1'b0};
        vecs[2] = '{0, 2, 4, 4, 3, 1'b1};
        vecs[3] = '{1, 3, 3, 5, 4, 1'b0};
        vecs[4] = '{5, 0, 2, 8, 1, 1'b1};

        rst = 1'b1; arm = 1'b0; abort = 1'b0; cfg_fwd = '0; cfg_rdc = '0;
        bus.smp_tvalid = 1'b0; bus.smp_tkeep = '0; bus.smp_tdata = '0;
        bus.trigger = 1'b0; bus.tx_tready = 1'b0;
        repeat (3) step();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_init", {63'd0, init}, 64'd0);
        chk("rst_mwr_tvalid", {63'd0, bus.mwr_tvalid}, 64'd0);
        chk("rst_mwr_tlast", {63'd0, bus.mwr_tlast}, 64'd0);
        chk("rst_mwr_tkeep", 64'(bus.mwr_tkeep), 64'd0);
        chk("rst_mwr_tdata", 64'(bus.mwr_tdata), 64'd0);
        chk("rst_mrd_tready", {63'd0, bus.mrd_tready}, 64'd0);
        chk("rst_tx_tvalid", {63'd0, bus.tx_tvalid}, 64'd0);
        chk("rst_tx_tdata", 64'(bus.tx_tdata), 64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++)
            run_capture($sformatf("vec%0d", i), vecs[i].fwd, vecs[i].rdc, vecs[i].trig,
                        vecs[i].exp_w, vecs[i].exp_r, vecs[i].rnd);

        for (int i = 0; i < 10; i++) begin
            fwd  = $urandom_range(0, 6);
            trig = $urandom_range(1, 6);
            w    = model_writes(fwd, trig);
            rdc  = $urandom_range(0, (w - 1 < 5) ? w - 1 : 5);
            run_capture($sformatf("rnd%0d", i), fwd, rdc, trig, w, rdc + 1, i[0]);
        end

        // Abort in DELAY; an arm there must be ignored.
        clear_mon();
        cfg_fwd = 16'd10; cfg_rdc = 16'd0;
        arm = 1'b1; step(); arm = 1'b0;
        bus.smp_tvalid = 1'b1; bus.trigger = 1'b1; bus.smp_tdata = $urandom; step();
        bus.trigger = 1'b0;
        step(); step();
        arm = 1'b1; step(); arm = 1'b0;
        chk("arm_ignored_init", {63'd0, init}, 64'd0);
        chk("arm_ignored_busy", {63'd0, busy}, 64'd1);
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_mwr_tvalid", {63'd0, bus.mwr_tvalid}, 64'd0);
        repeat (5) step();
        chk("abort_wr_total", 64'(wr_q.size()), 64'd4);
        chk("abort_no_rd", 64'(rd_pulses), 64'd0);
        bus.smp_tvalid = 1'b0;
        step();

        // Back-pressure in SEND, then reset while a word is pending.
        clear_mon();
        bus.tx_tready = 1'b0;
        cfg_fwd = 16'd0; cfg_rdc = 16'd0;
        arm = 1'b1; step(); arm = 1'b0;
        d = $urandom;
        bus.smp_tvalid = 1'b1; bus.trigger = 1'b1; bus.smp_tdata = d; step();
        bus.smp_tvalid = 1'b0; bus.trigger = 1'b0;
        cyc = 0;
        while (bus.tx_tvalid !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("hold_reach", {63'd0, bus.tx_tvalid}, 64'd1);
        chk("hold_data", 64'(bus.tx_tdata), 64'(d));
        p = rd_pulses;
        serr = 0;
        repeat (10) begin
            step();
            if (bus.tx_tdata !== d || bus.tx_tvalid !== 1'b1) serr++;
        end
        chk("hold_stable", 64'(serr), 64'd0);
        chk("hold_no_rd", 64'(rd_pulses), 64'(p));
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_send_tx_tvalid", {63'd0, bus.tx_tvalid}, 64'd0);
        chk("rst_send_busy", {63'd0, busy}, 64'd0);
        bus.tx_tready = 1'b1;
        n = rd_pulses;
        repeat (4) step();
        chk("rst_send_no_rd", 64'(rd_pulses), 64'(n));

`ifdef CAPTURE_COUNT_EN
        run_capture("cnt", 1, 0, 5, 7, 1, 1'b0);
        chk("cap_count_7", 64'(cap_count), 64'd7);
        arm = 1'b1; step(); arm = 1'b0;
        chk("cap_count_arm", 64'(cap_count), 64'd0);
        abort = 1'b1; step(); abort = 1'b0;
`endif

        chk("rd_wr_overlap", 64'(overlap), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
